// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the CPE CPU load/store path.
// It performs RV32I byte/half/word accesses on a word array, inserts wait states and signals completion with a done pulse.
module dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk_w_i,
  input  logic        rst_w_i_l,
  input  logic        mem_rd_w_i_h,
  input  logic        mem_wr_w_i_h,
  input  logic [2:0]  funct3_w_i,
  input  logic [31:0] addr_w_i,
  input  logic [31:0] wr_data_w_i,
  output logic [31:0] rd_data_w_o,
  output logic        stall_w_o_h,
  output logic        done_w_o_h,
  output logic        err_w_o_h
);

  localparam int         IDXW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wrData_q, rdData_q;
  logic [2:0]  funct3_q;
  logic        isRd_q, isWr_q, err_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic            req;
  logic [IDXW-1:0] wordIdx;
  logic [31:0]     memWord, loadData, wrMerge;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [3:0]      byteEn;
  logic            f3LoadOk, f3StoreOk, misHalf, misWord, outOfRange, accessErr, memWe;

  assign req         = mem_rd_w_i_h | mem_wr_w_i_h;
  assign stall_w_o_h = rst_w_i_l & req & (state_q != DONE);
  assign done_w_o_h  = (state_q == DONE);
  assign err_w_o_h   = done_w_o_h & err_q;
  assign rd_data_w_o = rdData_q;

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DONE returns to IDLE unconditionally so a held request costs one idle cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ACCESS;
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      addr_q   <= '0;
      wrData_q <= '0;
      funct3_q <= '0;
      isRd_q   <= 1'b0;
      isWr_q   <= 1'b0;
    end else if (state_q == IDLE && req) begin
      addr_q   <= addr_w_i;
      wrData_q <= wr_data_w_i;
      funct3_q <= funct3_w_i;
      isRd_q   <= mem_rd_w_i_h;
      isWr_q   <= mem_wr_w_i_h;
    end
  end

  assign wordIdx    = addr_q[IDXW+1:2];
  assign memWord    = mem_q[wordIdx];
  assign outOfRange = (addr_q >> (IDXW + 2)) != 32'd0;
  assign f3LoadOk   = funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign f3StoreOk  = funct3_q inside {3'b000, 3'b001, 3'b010};
  assign misHalf    = (funct3_q[1:0] == 2'b01) & addr_q[0];
  assign misWord    = (funct3_q[1:0] == 2'b10) & (addr_q[1:0] != 2'b00);
  assign accessErr  = (isRd_q & isWr_q) | misHalf | misWord | outOfRange |
                      (isRd_q & ~f3LoadOk) | (isWr_q & ~f3StoreOk);
  assign memWe      = (state_q == ACCESS) & isWr_q & ~accessErr;

  always_comb begin
    loadByte = memWord[7:0];
    case (addr_q[1:0])
      2'd1:    loadByte = memWord[15:8];
      2'd2:    loadByte = memWord[23:16];
      2'd3:    loadByte = memWord[31:24];
      default: loadByte = memWord[7:0];
    endcase
    loadHalf = addr_q[1] ? memWord[31:16] : memWord[15:0];
    case (funct3_q)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  loadData = memWord;
      3'b100:  loadData = {24'd0, loadByte};
      3'b101:  loadData = {16'd0, loadHalf};
      default: loadData = 32'd0;
    endcase
  end

  // Store data is replicated across lanes; byteEn selects which lanes land.
  always_comb begin
    byteEn  = 4'b1111;
    wrMerge = wrData_q;
    case (funct3_q[1:0])
      2'b00: begin
        byteEn  = 4'b0001 << addr_q[1:0];
        wrMerge = {4{wrData_q[7:0]}};
      end
      2'b01: begin
        byteEn  = addr_q[1] ? 4'b1100 : 4'b0011;
        wrMerge = {2{wrData_q[15:0]}};
      end
      default: begin
        byteEn  = 4'b1111;
        wrMerge = wrData_q;
      end
    endcase
  end

  always_ff @(posedge clk_w_i) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem_q[wordIdx][8*i +: 8] <= wrMerge[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      rdData_q <= 32'd0;
      err_q    <= 1'b0;
    end else if (state_q == ACCESS) begin
      rdData_q <= (isRd_q & ~accessErr) ? loadData : 32'd0;
      err_q    <= accessErr;
    end
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the CPE CPU: the memory-side end of the load/store control path. It accepts the `mem_rd`/`mem_wr` requests raised by the core's control decoder, performs RV32I byte, half and word accesses on an internal word-addressed array, and applies load sign/zero extension. It stalls the core for a programmable number of wait states and signals completion with a one-cycle done pulse.

## Interface
- `DEPTH_WORDS`, 1024: array depth in 32-bit words; power of two, at least 2.
- `WAIT_CYCLES`, 0: extra wait-state cycles per access; range 0..15.
- `clk_w_i` input 1: clock; all state updates on the rising edge.
- `rst_w_i_l` input 1: asynchronous active-low reset. Assertion is asynchronous.
- `mem_rd_w_i_h` input 1: load request, from the control decoder.
- `mem_wr_w_i_h` input 1: store request, from the control decoder.
- `funct3_w_i` input 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_w_i` input 32: byte address (ALU result).
- `wr_data_w_i` input 32: store data (rs2); the low byte/half is used for SB/SH.
- `rd_data_w_o` output 32: extended load data; valid only while `done_w_o_h` is high.
- `stall_w_o_h` output 1: core must hold the PC and pipeline.
- `done_w_o_h` output 1: one-cycle completion pulse.
- `err_w_o_h` output 1: access rejected; pulses together with `done_w_o_h`.

## Operation
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE, with `req = mem_rd_w_i_h | mem_wr_w_i_h` high:
  - Latch `addr_w_i`, `wr_data_w_i`, `funct3_w_i` and the read/write bits.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES` > 0, else go to ACCESS.
- WAIT: decrement the counter; go to ACCESS when it reaches 1.
- ACCESS: check the latched request for errors, then either perform it or reject it. Always go to DONE.
  - Write: update only the selected byte lanes of word `addr[log2(DEPTH_WORDS)+1:2]`.
  - Read: register the extended result.
- DONE: `done_w_o_h`=1, `rd_data_w_o` valid (0 for stores and errors). Go to IDLE unconditionally, so a request still held this cycle is not re-accepted.
- Error conditions (no array change, `rd_data_w_o`=0, `err_w_o_h`=1 in DONE):
  - Both rd and wr high.
  - Halfword access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
  - Word index ≥ `DEPTH_WORDS` (any nonzero address bit above the index field).
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
- Byte order is little-endian. Lane = `addr[1:0]` for bytes, `addr[1]` for halves.
- Load extension:
  - B/H: sign-extend bit 7 / bit 15 of the selected lane.
  - BU/HU: zero-extend.
  - W: pass through.
- `stall_w_o_h = req & ~(state==DONE)`, combinational. It is high in the request cycle and stays high until the DONE cycle.

## Timing
- Reset (async, `rst_w_i_l`=0) forces:
  - state IDLE, counter 0
  - `rd_data_w_o`=0, `done_w_o_h`=0, `err_w_o_h`=0
  - `stall_w_o_h` = 0 while `rst_w_i_l` is low, regardless of `req`
- Array contents are not reset.
- Reset mid-operation: a store is committed only if the ACCESS-cycle rising edge completed before reset. A store caught in WAIT is aborted.
- Latency: request first seen in cycle c0; `done_w_o_h` is high in cycle c0 + 2 + `WAIT_CYCLES`.
- `stall_w_o_h` is high for 2 + `WAIT_CYCLES` cycles (c0 through c0 + 1 + `WAIT_CYCLES`).
- Back-to-back requests: the earliest acceptance of the next request is the cycle after DONE, giving a minimum period of 3 + `WAIT_CYCLES`.
- Inputs are sampled only in IDLE. Changes during WAIT/ACCESS/DONE are ignored.

## Test plan
- `WAIT_CYCLES`=0:
  - SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> `rd_data_w_o`=0xDEADBEEF.
  - `done_w_o_h` high on c2 of each access; `stall_w_o_h` high for exactly 2 cycles per access.
- SB 0x80 to addr 0x21, then:
  - LW 0x20 -> 0x00008000 (word previously 0).
  - LB 0x21 -> 0xFFFFFF80.
  - LBU 0x21 -> 0x00000080.
  - LH 0x20 -> 0xFFFF8000.
- Misaligned accesses: LHU addr 0x23, SW addr 0x22, and LW with word index = `DEPTH_WORDS` (addr = 4·`DEPTH_WORDS`) -> `err_w_o_h`=1 with `done_w_o_h`, `rd_data_w_o`=0, memory unchanged (verify by readback).
- `WAIT_CYCLES`=3: LW -> `done_w_o_h` on c5, `stall_w_o_h` high for exactly 5 cycles; input changes during the wait are ignored.
- Reset during WAIT of an SW to 0x40 (`WAIT_CYCLES`=3, reset in c2):
  - During reset: all outputs 0, state IDLE.
  - After reset, LW 0x40 returns the old value.
- `mem_rd_w_i_h` and `mem_wr_w_i_h` both high:
  - `err_w_o_h`=1 and `done_w_o_h`=1 in c2, no array write.
  - With the request held high, the next acceptance is in c3.
